imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator for the LEGv8 decode stage. Classifies each
//  32-bit instruction as B, CB, D, I or IW and emits the immediate, sign- or zero-extended to
//  DATA_W. Branch offsets are optionally pre-shifted. Valid/ready handshakes on both sides give
//  2-cycle latency, and the block counts illegal encodings. Sits between fetch buffer and ALU/branch-target logic.
// PARAMETERS
//  DATA_W     64  output immediate width; legal values 32 or 64
//  SHIFT_BR   1   1: B/CB immediates shifted left by 2 (byte offset); 0: word offset
//  ERR_CNT_W  8   width of saturating illegal-instruction counter
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          asynchronous reset, active-high
//  flush       in   1          synchronous pipeline flush
//  in_valid    in   1          in_instr valid
//  in_ready    out  1          block accepts in_instr this cycle
//  in_instr    in   32         instruction word
//  out_valid   out  1          out_* valid
//  out_ready   in   1          consumer accepts out_* this cycle
//  out_imm     out  DATA_W     extended immediate
//  out_fmt     out  3          0=NONE 1=B 2=CB 3=D 4=I 5=IW
//  out_illegal out  1          out_fmt==NONE
//  err_count   out  ERR_CNT_W  saturating count of delivered illegal instructions
// BEHAVIOUR
//  Reset: all stage valids=0; out_valid=0; out_imm=0; out_fmt=0; out_illegal=0; err_count=0.
//  Decode (S1, first match wins):
//   IW: instr[31:23]==9'b110100101 or 9'b111100101 (MOVZ/MOVK). Value is zext(instr[20:5]) << (16*instr[22:21]).
//   B : instr[30:26]==5'b00101. Value is sext(instr[25:0]).
//   CB: instr[31:25]==7'b1011010 or instr[31:24]==8'b01010100. Value is sext(instr[23:5]).
//   D : instr[29:27]==3'b111 and instr[25:24]==2'b00. Value is sext(instr[20:12]).
//   I : instr[28:26]==3'b100. Value is zext(instr[21:10]).
//   else NONE: imm=0, illegal=1.
//  Shift/extend (S2): B/CB shifted left by 2 when SHIFT_BR=1, before sign extension to DATA_W.
//   IW bits shifted beyond DATA_W are dropped. DATA_W=32 with hw>=2 yields 0; this is not an error.
//  Pipeline: S1 register (instr, fmt), then S2 register (out_*). Latency 2 cycles from accepted input to out_valid.
//   s2_adv = !out_valid | out_ready;  s1_adv = s1_valid & s2_adv;
//   in_ready = !s1_valid | s2_adv. Combinational from out_ready; documented, no skid buffer.
//   Accept when in_valid & in_ready. Full throughput of 1 per cycle while out_ready=1.
//   out_* held stable while out_valid & !out_ready.
//   Max 2 instructions in flight; in_ready=0 when both stages full and out_ready=0.
//  err_count increments on out_valid & out_ready & out_illegal. It saturates at all-ones and is never cleared by flush.
//  flush: next edge clears s1_valid and out_valid. An input offered in the flush cycle is dropped.
//   flush overrides a same-cycle accept; in_ready is still reported normally.
//  Reset mid-operation: in-flight instructions discarded; outputs return to reset values immediately.
// TESTING
//  1 B 0x17FFFFFF, SHIFT_BR=1, out_ready=1 -> 2 cycles later out_fmt=1, out_imm=64'hFFFF_FFFF_FFFF_FFFC.
//  2 CBZ imm19=19'h40000 (0xB4800000); then LDUR imm9=9'h1FF (0xF85FF000) ->
//    out_imm=64'hFFFF_FFFF_FFF0_0000 fmt=2; then out_imm=64'hFFFF_FFFF_FFFF_FFFF fmt=3.
//  3 MOVZ hw=2 imm16=0xABCD (0xD2D579A0) -> out_imm=64'h0000_ABCD_0000_0000 fmt=5.
//    The same instruction with DATA_W=32 -> out_imm=0.
//  4 Stream 4 valid instructions, out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted.
//    On release, all 4 are delivered in order with no loss or duplication.
//  5 Feed 300 illegal words 0x00000000 with ERR_CNT_W=8 -> each out_illegal=1, imm=0; err_count ends at 255.
//  6 Assert rst (async, mid-clock) with 2 in flight -> out_valid=0 at once; err_count=0.
//    Then flush with in_valid=1 -> no output for the dropped word.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// LEGv8 immediate generator: two-stage valid/ready pipeline with decode in
// S1 and shift/extend in S2, plus a saturating illegal-instruction counter.
module imm_extend_pipe #(
  parameter int DATA_W    = 64,
  parameter bit SHIFT_BR  = 1'b1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_imm,
  output logic [2:0]           out_fmt,
  output logic                 out_illegal,
  output logic [ERR_CNT_W-1:0] err_count
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_w
    $error("imm_extend_pipe: DATA_W must be 32 or 64");
  end

  typedef enum logic [2:0] {
    F_NONE = 3'd0,
    F_B    = 3'd1,
    F_CB   = 3'd2,
    F_D    = 3'd3,
    F_I    = 3'd4,
    F_IW   = 3'd5
  } fmt_e;

  // Only instr[25:0] carries immediate bits in any format.
  typedef struct packed {
    logic [25:0] body;
    fmt_e        fmt;
  } s1_t;

  localparam int unsigned BR_SH = SHIFT_BR ? 2 : 0;

  logic w_m_iw;
  logic w_m_b;
  logic w_m_cb;
  logic w_m_d;
  logic w_m_i;
  logic w_sel_iw;
  logic w_sel_b;
  logic w_sel_cb;
  logic w_sel_d;
  logic w_sel_i;
  fmt_e w_fmt;

  logic w_s2_adv;
  logic w_s1_adv;
  logic w_accept;

  logic        r_s1_valid;
  s1_t         r_s1;
  logic [63:0] w_imm64;

  assign w_m_iw = (in_instr[31:23] == 9'b110100101) |
                  (in_instr[31:23] == 9'b111100101);
  assign w_m_b  = (in_instr[30:26] == 5'b00101);
  assign w_m_cb = (in_instr[31:25] == 7'b1011010) |
                  (in_instr[31:24] == 8'b01010100);
  assign w_m_d  = (in_instr[29:27] == 3'b111) &
                  (in_instr[25:24] == 2'b00);
  assign w_m_i  = (in_instr[28:26] == 3'b100);

  // Masking makes the one-hot select exclusive, so first match wins.
  assign w_sel_iw = w_m_iw;
  assign w_sel_b  = w_m_b & ~w_m_iw;
  assign w_sel_cb = w_m_cb & ~w_m_iw & ~w_m_b;
  assign w_sel_d  = w_m_d & ~w_m_iw & ~w_m_b & ~w_m_cb;
  assign w_sel_i  = w_m_i & ~w_m_iw & ~w_m_b & ~w_m_cb & ~w_m_d;

  always_comb begin
    w_fmt = F_NONE;
    unique case (1'b1)
      w_sel_iw: w_fmt = F_IW;
      w_sel_b:  w_fmt = F_B;
      w_sel_cb: w_fmt = F_CB;
      w_sel_d:  w_fmt = F_D;
      w_sel_i:  w_fmt = F_I;
      default:  w_fmt = F_NONE;
    endcase
  end

  assign w_s2_adv = ~out_valid | out_ready;
  assign w_s1_adv = r_s1_valid & w_s2_adv;
  assign in_ready = ~r_s1_valid | w_s2_adv;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1.body <= in_instr[25:0];
        r_s1.fmt  <= w_fmt;
      end
    end
  end

  // Extension is done at 64 bits and truncated, which drops high IW chunks.
  always_comb begin
    w_imm64 = '0;
    unique case (r_s1.fmt)
      F_IW: w_imm64 = {48'd0, r_s1.body[20:5]} << {r_s1.body[22:21], 4'd0};
      F_B:  w_imm64 = {{38{r_s1.body[25]}}, r_s1.body[25:0]} << BR_SH;
      F_CB: w_imm64 = {{45{r_s1.body[23]}}, r_s1.body[23:5]} << BR_SH;
      F_D:  w_imm64 = {{55{r_s1.body[20]}}, r_s1.body[20:12]};
      F_I:  w_imm64 = {52'd0, r_s1.body[21:10]};
      default: w_imm64 = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt     <= 3'd0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_s2_adv) begin
      out_valid <= r_s1_valid;
      if (w_s1_adv) begin
        out_imm     <= DATA_W'(w_imm64);
        out_fmt     <= r_s1.fmt;
        out_illegal <= (r_s1.fmt == F_NONE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid & out_ready & out_illegal & ~&err_count) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: a 64-bit and a 32-bit instance share
// stimulus; expected results queue on accept and are checked on delivery.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b0;

  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [7:0]  err_count;

  logic        w32_in_ready;
  logic        w32_out_valid;
  logic [31:0] w32_out_imm;
  logic [2:0]  w32_out_fmt;
  logic        w32_out_illegal;
  logic [7:0]  w32_err_count;

  typedef struct {
    string       tag;
    logic [63:0] imm;
    logic [31:0] imm32;
    logic [2:0]  fmt;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   ndel = 0;

  imm_extend_pipe #(.DATA_W(64), .SHIFT_BR(1'b1), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .err_count(err_count)
  );

  imm_extend_pipe #(.DATA_W(32), .SHIFT_BR(1'b1), .ERR_CNT_W(8)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(w32_in_ready), .in_instr(in_instr),
    .out_valid(w32_out_valid), .out_ready(out_ready),
    .out_imm(w32_out_imm), .out_fmt(w32_out_fmt),
    .out_illegal(w32_out_illegal), .err_count(w32_err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(input string t, input logic [63:0] i64,
                              input logic [31:0] i32, input logic [2:0] f);
    exp_t e;
    e.tag = t;
    e.imm = i64;
    e.imm32 = i32;
    e.fmt = f;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are stable since the previous falling edge; sample 1ns before rise.
  task automatic tick(output bit acc);
    bit   del;
    exp_t e;
    #4;
    acc = in_valid && in_ready && !flush;
    del = out_valid && out_ready;
    if (del) begin
      ndel++;
      chk("sb_has_entry", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.tag, "_imm"}, out_imm, e.imm);
        chk({e.tag, "_fmt"}, 64'(out_fmt), 64'(e.fmt));
        chk({e.tag, "_ill"}, 64'(out_illegal), 64'(e.fmt == 3'd0));
        chk({e.tag, "_v32"}, 64'(w32_out_valid), 64'd1);
        chk({e.tag, "_imm32"}, 64'(w32_out_imm), 64'(e.imm32));
        chk({e.tag, "_fmt32"}, 64'(w32_out_fmt), 64'(e.fmt));
        chk({e.tag, "_ill32"}, 64'(w32_out_illegal), 64'(e.fmt == 3'd0));
      end
    end
    if (flush) q.delete();
    if (acc) q.push_back(cur);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input exp_t e,
                      input bit ordy, input bit fl, output bit acc);
    in_valid = v;
    in_instr = ins;
    out_ready = ordy;
    flush = fl;
    cur = e;
    tick(acc);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, cur, ordy, 1'b0, a);
  endtask

  localparam logic [31:0] I_B   = 32'h17FF_FFFF;
  localparam logic [31:0] I_CB  = 32'hB480_0000;
  localparam logic [31:0] I_LD  = 32'hF85F_F000;
  localparam logic [31:0] I_MOV = 32'hD2D5_79A0;

  initial begin
    bit    a;
    exp_t  e_b, e_cb, e_ld, e_mov, e_ill;
    exp_t  seq4[4];
    logic [31:0] ins4[4];
    int    idx;
    int    d0;

    e_b   = mk("b",   64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd1);
    e_cb  = mk("cb",  64'hFFFF_FFFF_FFF0_0000, 32'hFFF0_0000, 3'd2);
    e_ld  = mk("ld",  64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd3);
    e_mov = mk("mov", 64'h0000_ABCD_0000_0000, 32'h0000_0000, 3'd5);
    e_ill = mk("ill", 64'h0, 32'h0, 3'd0);
    cur = e_ill;

    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'd0);
    chk("rst_ill", 64'(out_illegal), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    step(1'b1, I_B, e_b, 1'b1, 1'b0, a);
    chk("t1_acc", 64'(a), 64'd1);
    chk("t1_lat1", 64'(out_valid), 64'd0);
    idle(1, 1'b1);
    chk("t1_lat2", 64'(out_valid), 64'd1);
    idle(2, 1'b1);

    step(1'b1, I_CB, e_cb, 1'b1, 1'b0, a);
    step(1'b1, I_LD, e_ld, 1'b1, 1'b0, a);
    idle(3, 1'b1);

    step(1'b1, I_MOV, e_mov, 1'b1, 1'b0, a);
    idle(3, 1'b1);
    chk("t3_drained", 64'(q.size()), 64'd0);

    ins4 = '{I_B, I_CB, I_LD, I_MOV};
    seq4 = '{e_b, e_cb, e_ld, e_mov};
    foreach (seq4[k]) seq4[k].tag = $sformatf("t4_%0d", k);
    idx = 0;
    d0 = ndel;
    for (int c = 0; c < 30; c++) begin
      if (idx < 4) step(1'b1, ins4[idx], seq4[idx], c >= 5, 1'b0, a);
      else step(1'b0, 32'h0, cur, 1'b1, 1'b0, a);
      if (a) idx++;
      if (c == 4) begin
        chk("t4_held_acc", 64'(idx), 64'd2);
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        chk("t4_in_ready32", 64'(w32_in_ready), 64'd0);
        chk("t4_out_hold", out_imm, e_b.imm);
      end
      if (c > 5 && idx == 4 && q.size() == 0 && !out_valid) break;
    end
    chk("t4_all_acc", 64'(idx), 64'd4);
    chk("t4_delivered", 64'(ndel - d0), 64'd4);
    chk("t4_sb_empty", 64'(q.size()), 64'd0);

    chk("t5_err_start", 64'(err_count), 64'd0);
    for (int n = 0; n < 300; n++) step(1'b1, 32'h0, e_ill, 1'b1, 1'b0, a);
    idle(3, 1'b1);
    chk("t5_err_sat", 64'(err_count), 64'd255);
    chk("t5_err_sat32", 64'(w32_err_count), 64'd255);
    chk("t5_sb_empty", 64'(q.size()), 64'd0);

    step(1'b1, I_CB, e_cb, 1'b0, 1'b0, a);
    step(1'b1, I_LD, e_ld, 1'b0, 1'b0, a);
    in_valid = 1'b0;
    chk("t6_inflight", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_err", 64'(err_count), 64'd0);
    chk("t6_async_imm", out_imm, 64'd0);
    chk("t6_async_fmt", 64'(out_fmt), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, I_MOV, e_mov, 1'b1, 1'b1, a);
    chk("t6_flush_drop_valid", 64'(out_valid), 64'd0);
    idle(4, 1'b1);
    chk("t6_flush_no_out", 64'(out_valid), 64'd0);

    step(1'b1, I_B, e_b, 1'b0, 1'b0, a);
    step(1'b1, I_CB, e_cb, 1'b0, 1'b0, a);
    step(1'b0, 32'h0, cur, 1'b0, 1'b1, a);
    chk("t6_flush_clr", 64'(out_valid), 64'd0);
    idle(4, 1'b1);
    chk("t6_flush_sb", 64'(q.size()), 64'd0);
    chk("t6_err_kept", 64'(err_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
